// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package instr_fetch_pkg;

  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  // PC-relative branch offset field inside the instruction word
  localparam int BR_OFF_LSB = 0;
  localparam int BR_OFF_MSB = 7;
  localparam int BR_OFF_W   = BR_OFF_MSB - BR_OFF_LSB + 1;

  // Debug encodings shown on fetch_state (WAIT deliberately shares START's code)
  localparam logic [1:0] DBG_START = 2'd0;
  localparam logic [1:0] DBG_FETCH = 2'd1;
  localparam logic [1:0] DBG_LOAD  = 2'd2;
  localparam logic [1:0] DBG_EXEC  = 2'd3;
  localparam logic [1:0] DBG_WAIT  = 2'd0;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WAIT  = 3'd4
  } fetch_state_e;

  // Map internal state to the 2-bit debug LED code
  function automatic logic [1:0] dbg_code(fetch_state_e s);
    logic [1:0] code;
    case (s)
      ST_START: code = DBG_START;
      ST_FETCH: code = DBG_FETCH;
      ST_LOAD:  code = DBG_LOAD;
      ST_EXEC:  code = DBG_EXEC;
      ST_WAIT:  code = DBG_WAIT;
      default:  code = DBG_START;
    endcase
    return code;
  endfunction

  // Sign-extend the branch offset field to 32 bits; callers truncate to ADDR_W
  function automatic logic [31:0] sext_br_off(logic [INSTR_W-1:0] ins);
    return {{(32-BR_OFF_W){ins[BR_OFF_MSB]}}, ins[BR_OFF_MSB:BR_OFF_LSB]};
  endfunction

endpackage

// File: rtl/instr_fetch_step_edge.sv
// Step button: 2-flop synchronizer followed by a rising-edge pulse generator.
module step_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  output logic step_pulse
);

  logic sync1_q, sync2_q;
  logic hist_q;

  // Synchronizer flops reset to 1 so a button held through reset is treated as
  // an already-seen press; any pulse this makes during reset/START is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= step;
      sync2_q <= sync1_q;
    end
  end

  // Edge history register, one cycle behind the synchronizer output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= sync2_q;
    end
  end

  assign step_pulse = sync2_q & ~hist_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/sequencing: PC, ROM interface, instruction register, next-PC.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               step,
  input  logic [INSTR_W-1:0] im_data,
  input  logic               branch_taken,
  input  logic               imadd_sl,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic               im_en,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [1:0]         fetch_state
);

  fetch_state_e state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;             // address of the word held in instr
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d; // address of the next word to fetch
  logic [ADDR_W-1:0]  next_pc;
  logic               step_pulse;

  step_edge u_step_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (step),
    .step_pulse (step_pulse)
  );

  // Next-PC select: jump beats branch beats sequential, all modulo 2^ADDR_W
  always_comb begin
    next_pc = pc_q + ADDR_W'(1);
    if (imadd_sl) begin
      next_pc = jump_addr;
    end else if (branch_taken) begin
      next_pc = pc_q + ADDR_W'(1) + ADDR_W'(sext_br_off(instr_q));
    end
  end

  // Sequencer next state; step pulses outside WAIT are simply ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START: state_d = run ? ST_FETCH : ST_WAIT;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_EXEC;
      ST_EXEC:  state_d = run ? ST_FETCH : ST_WAIT;
      ST_WAIT:  if (run || step_pulse) state_d = ST_FETCH;
      default:  state_d = ST_START;
    endcase
  end

  // Datapath next values: capture instruction in LOAD, advance fetch PC in EXEC
  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    if (state_q == ST_LOAD) begin
      instr_d = im_data;
      pc_d    = fetch_pc_q;
    end
    if (state_q == ST_EXEC) begin
      fetch_pc_d = next_pc;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_START;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction register and PCs; reset abandons any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign im_en       = (state_q == ST_FETCH);
  assign im_addr     = fetch_pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == ST_EXEC);
  assign pc          = pc_q;
  assign fetch_state = dbg_code(state_q);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector table, directed sequences, random run.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [15:0] im_data = 16'h0000;
  logic        branch_taken = 1'b0;
  logic        imadd_sl = 1'b0;
  logic [7:0]  jump_addr = 8'h00;
  logic        im_en;
  logic [7:0]  im_addr;
  logic [15:0] instr;
  logic        instr_valid;
  logic [7:0]  pc;
  logic [1:0]  fetch_state;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [15:0] rom [256];

  instr_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .step         (step),
    .im_data      (im_data),
    .branch_taken (branch_taken),
    .imadd_sl     (imadd_sl),
    .jump_addr    (jump_addr),
    .im_en        (im_en),
    .im_addr      (im_addr),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .fetch_state  (fetch_state)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model: data one cycle after enable/address
  always @(posedge clk) begin
    if (im_en) im_data <= rom[im_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", name, got, exp, $time);
    end else begin
      $display("ok   %s = 0x%0h", name, got);
    end
  endtask

  // Advance to the negedge of the next EXEC cycle, bounded
  task automatic wait_exec(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_exec timeout got=no_instr_valid exp=instr_valid");
    end
  endtask

  // Drive decoder inputs for the current EXEC cycle, then release them
  task automatic apply(input logic br, input logic js, input logic [7:0] ja);
    branch_taken = br;
    imadd_sl     = js;
    jump_addr    = ja;
    @(negedge clk);
    branch_taken = 1'b0;
    imadd_sl     = 1'b0;
    jump_addr    = 8'h00;
  endtask

  task automatic do_reset(input logic r);
    rst_n = 1'b0;
    run = r;
    step = 1'b0;
    branch_taken = 1'b0;
    imadd_sl = 1'b0;
    jump_addr = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] start_pc;
    logic [7:0] off;
    logic       br;
    logic       js;
    logic [7:0] ja;
    logic [7:0] exp_pc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit ok;
    int t_prev;
    int busy;
    int exp_pc;
    logic [7:0] off8;
    logic br, js;
    logic [7:0] ja;

    // Next-PC vectors: start pc, offset byte, branch, jump, jump addr, expected pc
    vecs[0] = '{8'h10, 8'hFC, 1'b1, 1'b0, 8'h00, 8'h0D};
    vecs[1] = '{8'h10, 8'h05, 1'b1, 1'b0, 8'h00, 8'h16};
    vecs[2] = '{8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[3] = '{8'hFE, 8'h03, 1'b1, 1'b0, 8'h00, 8'h02};
    vecs[4] = '{8'h20, 8'h7F, 1'b1, 1'b1, 8'h40, 8'h40};
    vecs[5] = '{8'h30, 8'h80, 1'b1, 1'b0, 8'h00, 8'hB1};
    vecs[6] = '{8'h30, 8'h80, 1'b0, 1'b0, 8'h00, 8'h31};
    vecs[7] = '{8'h55, 8'h10, 1'b0, 1'b1, 8'h07, 8'h07};

    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;

    // ---- Reset values ----
    rst_n = 1'b0;
    run = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 8'h00);
    chk("rst_im_addr", im_addr, 8'h00);
    chk("rst_im_en", im_en, 1'b0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_fetch_state", fetch_state, 2'd0);

    // ---- Sequential run: A, B, C every 3 cycles ----
    rom[0] = 16'hA1A1; rom[1] = 16'hB2B2; rom[2] = 16'hC3C3;
    do_reset(1'b1);
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_exec(ok);
      chk($sformatf("seq_pc%0d", k), pc, k);
      chk($sformatf("seq_instr%0d", k), instr, rom[k]);
      if (k > 0) chk($sformatf("seq_spacing%0d", k), cyc - t_prev, 3);
      t_prev = cyc;
    end

    // ---- Next-PC table ----
    for (int v = 0; v < 8; v++) begin
      rom[vecs[v].start_pc] = {8'h5A, vecs[v].off};
      do_reset(1'b1);
      wait_exec(ok);
      apply(1'b0, 1'b1, vecs[v].start_pc);
      wait_exec(ok);
      chk($sformatf("vec%0d_start_pc", v), pc, vecs[v].start_pc);
      apply(vecs[v].br, vecs[v].js, vecs[v].ja);
      wait_exec(ok);
      chk($sformatf("vec%0d_next_pc", v), pc, vecs[v].exp_pc);
    end

    // ---- Random program against reference model ----
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    do_reset(1'b1);
    exp_pc = 0;
    t_prev = 0;
    for (int k = 0; k < 40; k++) begin
      wait_exec(ok);
      chk($sformatf("rnd%0d_pc", k), pc, exp_pc);
      chk($sformatf("rnd%0d_instr", k), instr, rom[exp_pc]);
      if (k > 0) chk($sformatf("rnd%0d_spacing", k), cyc - t_prev, 3);
      t_prev = cyc;
      js = ($urandom_range(0, 5) == 0);
      br = ($urandom_range(0, 2) == 0);
      ja = 8'($urandom);
      off8 = rom[exp_pc][7:0];
      if (js) exp_pc = ja;
      else if (br) exp_pc = (exp_pc + 1 + int'($signed(off8))) & 255;
      else exp_pc = (exp_pc + 1) & 255;
      apply(br, js, ja);
    end

    // ---- Single-step mode ----
    rom[0] = 16'h1111; rom[1] = 16'h2222;
    do_reset(1'b0);
    busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (im_en || instr_valid || fetch_state != 2'd0) busy++;
    end
    chk("step_idle_before", busy, 0);
    step = 1'b1;                   // c0: rise
    @(negedge clk); step = 1'b0;   // c1
    chk("step_c1_wait", fetch_state, 2'd0);
    @(negedge clk); step = 1'b1;   // c2: second rise, detected during LOAD
    chk("step_c2_wait", fetch_state, 2'd0);
    @(negedge clk);                // c3
    chk("step_c3_fetch", fetch_state, 2'd1);
    chk("step_c3_im_en", im_en, 1'b1);
    @(negedge clk);                // c4
    chk("step_c4_load", fetch_state, 2'd2);
    @(negedge clk);                // c5
    chk("step_c5_valid", instr_valid, 1'b1);
    chk("step_c5_pc", pc, 8'h00);
    chk("step_c5_instr", instr, 16'h1111);
    busy = 0;
    repeat (8) begin
      @(negedge clk);
      if (im_en || instr_valid || fetch_state != 2'd0) busy++;
    end
    chk("step_second_ignored", busy, 0);
    step = 1'b0;

    // run asserted in WAIT starts fetching; dropped mid-instruction completes it
    run = 1'b1;
    @(negedge clk);
    chk("run_wait_to_fetch", fetch_state, 2'd1);
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("run_drop_exec", instr_valid, 1'b1);
    chk("run_drop_pc", pc, 8'h01);
    @(negedge clk);
    chk("run_drop_wait_state", fetch_state, 2'd0);
    chk("run_drop_wait_im_en", im_en, 1'b0);

    // ---- Reset during LOAD ----
    rom[0] = 16'h7777;
    rom[1] = 16'h8888;
    rom[2] = 16'h9999;
    do_reset(1'b1);
    repeat (2) wait_exec(ok);
    busy = 0;
    while (fetch_state != 2'd2 && busy < 10) begin
      @(negedge clk);
      busy++;
    end
    chk("rl_in_load", fetch_state, 2'd2);
    chk("rl_pc_before", pc, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("rl_pc", pc, 8'h00);
    chk("rl_instr", instr, 16'h0000);
    chk("rl_valid", instr_valid, 1'b0);
    chk("rl_im_en", im_en, 1'b0);
    chk("rl_state", fetch_state, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_exec(ok);
    chk("rl_restart_pc", pc, 8'h00);
    chk("rl_restart_instr", instr, 16'h7777);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and sequencing stage of the 16-bit FPGA processor. Owns the program counter, drives the synchronous instruction ROM, and holds the fetched word in an instruction register feeding the combinational instruction decoder. Also resolves next-PC (sequential, PC-relative branch, register-indirect jump) from decoder/datapath inputs. Supports free-running and single-step (board button) execution.

## Interface
- ADDR_W, 8, instruction-memory address width (ROM depth 2^ADDR_W words)
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  1 = free-run; 0 = single-step mode
- step  in  1  raw step button level (asynchronous to clk)
- im_data  in  16  ROM read data, valid one cycle after im_en/im_addr
- branch_taken  in  1  decoder branch flag ANDed with resolved condition; sampled in EXEC
- imadd_sl  in  1  decoder jump select; 1 = next PC from jump_addr; sampled in EXEC
- jump_addr  in  ADDR_W  register-bank value for indirect jump
- im_en  out  1  ROM read enable
- im_addr  out  ADDR_W  ROM address
- instr  out  16  instruction register, drives decoder input
- instr_valid  out  1  high for exactly the EXEC cycle; datapath gates all write enables with it
- pc  out  ADDR_W  address of instruction in instr
- fetch_state  out  2  current state encoding, for debug LEDs

## Operation
- States: START(0), FETCH(1), LOAD(2), EXEC(3); plus WAIT encoded via separate flag? No — five states, encoding: START=0, FETCH=1, LOAD=2, EXEC=3 on fetch_state; WAIT reports 0 with im_en=0 (START and WAIT indistinguishable on debug output, by decision).
- START: one cycle after reset release; -> FETCH if run, else -> WAIT.
- FETCH: im_en=1, im_addr=pc; -> LOAD.
- LOAD: im_data captured into instr; -> EXEC.
- EXEC: instr_valid=1; PC updated at end of cycle; -> FETCH if run, else -> WAIT.
- WAIT: idle, im_en=0; on detected step rising edge -> FETCH; run asserting -> FETCH.
- Next PC priority in EXEC: imadd_sl=1 -> jump_addr; else branch_taken=1 -> pc + 1 + sext(instr[7:0]); else pc + 1. All arithmetic modulo 2^ADDR_W (wraps silently, no flag).
- Step edge seen in any state other than WAIT is discarded (no queueing).
- run dropping mid-instruction: current instruction completes through EXEC, then WAIT.
- imadd_sl and branch_taken both high: jump wins.

## Timing
- 3 cycles per instruction in run mode (FETCH, LOAD, EXEC); throughput one instruction / 3 clk.
- instr and pc stable from LOAD->EXEC edge until next LOAD->EXEC edge.
- step passes 2-flop synchronizer + edge detect: WAIT->FETCH occurs 3 cycles after step rises (synchronizer 2, edge register 1).
- Reset values: pc=RESET_PC, im_addr=RESET_PC, im_en=0, instr=16'h0000 (decodes to no-write NOP), instr_valid=0, fetch_state=0, edge-detect history=0 (button held through reset produces no step).
- Reset asserted mid-instruction: immediate clear of all above; in-flight instruction abandoned, no PC update.

## Structure
- Shared package: INSTR_W=16, NOP_INSTR=16'h0000, state encoding constants, branch offset field position [7:0].
- One sub-module: step_edge (2-flop synchronizer + rising-edge pulse, async active-low reset on clk/rst_n).
- Next-PC mux combinational inside instr_fetch; PC, instr, state registered.

## Test plan
- Reset with run=1, ROM[0..2]=A,B,C, no branches -> instr_valid pulses every 3 cycles, pc 0,1,2, instr A,B,C.
- At pc=0x10 with instr[7:0]=0xFC, branch_taken=1 -> next pc=0x0D; with 0x05 -> 0x16.
- pc=0xFF, no branch -> next pc=0x00; pc=0xFE, offset 0x03 taken -> 0x02.
- imadd_sl=1, jump_addr=0x40, branch_taken=1 simultaneously -> next pc=0x40.
- run=0: no fetch until step pulse; one pulse -> exactly one instr_valid, 3 cycles after edge+FETCH..EXEC; second pulse during LOAD ignored.
- rst_n low during LOAD -> same cycle pc=RESET_PC, instr=0, instr_valid=0, im_en=0; restart fetches from RESET_PC.
